rv32i_imem_loader: RTL and testbench

Boot-time program loader that sequences the instruction memory write port before the core runs. It receives a byte stream (length header followed by little-endian instruction words) over a valid/ready interface, assembles 32-bit words, and writes them to consecutive instruction-memory addresses using the wr_en/wr_valid handshake. It holds the core in reset until the load completes, then releases it. It sits between the external host link and the fetch stage's instruction-write ports.

---
 rtl/rv32i_imem_loader.sv | 183 ++++++++++++++++++
 tb/tb_rv32i_imem_loader.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_imem_loader.sv
// rv32i_imem_loader
//
// Boot-time program loader. It takes a byte stream made of a 4-byte little-endian
// word count N followed by N little-endian instruction words. Each word is written to
// consecutive instruction-memory addresses starting at LOAD_BASE_ADDR. The core is held
// in reset until the whole program has been written.
//
// Ports:
//   i_clk, i_rst      clock; synchronous active-high reset
//   i_start           one-cycle pulse that starts a load (taken in IDLE, DONE or ERROR)
//   i_rx_valid/data   byte stream input; a byte is taken when i_rx_valid && o_rx_ready
//   o_rx_ready        high in HDR and DATA only
//   o_wr_en           write request, held until i_wr_valid acknowledges it
//   o_wr_addr/data    write address/data, stable while o_wr_en is high
//   i_wr_valid        write-complete acknowledge from instruction memory
//   o_core_rst        core/fetch reset, low only in DONE
//   o_busy/done/error mutually exclusive status flags
//   o_words_written   acknowledged writes in the current load
module rv32i_imem_loader #(
   parameter logic [31:0] LOAD_BASE_ADDR = 32'd0,
   parameter int unsigned MAX_WORDS      = 1024,
   parameter int unsigned WR_TIMEOUT     = 64
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic        i_rx_valid,
   input  logic [7:0]  i_rx_data,
   output logic        o_rx_ready,
   output logic        o_wr_en,
   output logic [31:0] o_wr_addr,
   output logic [31:0] o_wr_data,
   input  logic        i_wr_valid,
   output logic        o_core_rst,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_error,
   output logic [31:0] o_words_written
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_HDR   = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_WRITE = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;
   localparam logic [2:0] ST_ERROR = 3'd5;

   localparam int unsigned TMO_W = (WR_TIMEOUT > 1) ? $clog2(WR_TIMEOUT) : 1;
   // Last WRITE cycle allowed without an acknowledge; the request is therefore
   // visible for exactly WR_TIMEOUT cycles before the loader gives up.
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(WR_TIMEOUT - 1);
   localparam logic [31:0]      MAX_N    = 32'(MAX_WORDS);

   logic [2:0]       state_q, state_d;
   logic [1:0]       byte_idx_q, byte_idx_d;
   logic [31:0]      asm_q, asm_d;
   logic [31:0]      word_cnt_q, word_cnt_d;
   logic [31:0]      word_idx_q, word_idx_d;
   logic [31:0]      wr_data_q, wr_data_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;

   logic             rx_take;
   logic             last_byte;
   logic [31:0]      asm_word;
   logic [31:0]      word_idx_inc;

   assign rx_take      = i_rx_valid && o_rx_ready;
   assign last_byte    = (byte_idx_q == 2'd3);
   assign word_idx_inc = word_idx_q + 32'd1;

   // Assembly register with the byte currently on the bus merged in at its
   // little-endian lane; used when the 4th byte completes a word.
   always_comb begin
      asm_word = asm_q;
      unique case (byte_idx_q)
         2'd0:    asm_word[7:0]   = i_rx_data;
         2'd1:    asm_word[15:8]  = i_rx_data;
         2'd2:    asm_word[23:16] = i_rx_data;
         default: asm_word[31:24] = i_rx_data;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      byte_idx_d = byte_idx_q;
      asm_d      = asm_q;
      word_cnt_d = word_cnt_q;
      word_idx_d = word_idx_q;
      wr_data_d  = wr_data_q;
      tmo_d      = tmo_q;

      unique case (state_q)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (i_start) begin
               state_d    = ST_HDR;
               byte_idx_d = 2'd0;
               asm_d      = 32'd0;
               word_idx_d = 32'd0;
            end
         end

         ST_HDR: begin
            if (rx_take) begin
               byte_idx_d = byte_idx_q + 2'd1;
               asm_d      = asm_word;
               if (last_byte) begin
                  word_cnt_d = asm_word;
                  asm_d      = 32'd0;
                  if (asm_word == 32'd0) begin
                     state_d = ST_DONE;
                  end else if (asm_word > MAX_N) begin
                     state_d = ST_ERROR;
                  end else begin
                     state_d = ST_DATA;
                  end
               end
            end
         end

         ST_DATA: begin
            if (rx_take) begin
               byte_idx_d = byte_idx_q + 2'd1;
               asm_d      = asm_word;
               if (last_byte) begin
                  wr_data_d = asm_word;
                  asm_d     = 32'd0;
                  tmo_d     = '0;
                  state_d   = ST_WRITE;
               end
            end
         end

         ST_WRITE: begin
            if (i_wr_valid) begin
               word_idx_d = word_idx_inc;
               state_d    = (word_idx_inc == word_cnt_q) ? ST_DONE : ST_DATA;
            end else if (tmo_q == TMO_LAST) begin
               state_d = ST_ERROR;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= ST_IDLE;
         byte_idx_q <= 2'd0;
         asm_q      <= 32'd0;
         word_cnt_q <= 32'd0;
         word_idx_q <= 32'd0;
         wr_data_q  <= 32'd0;
         tmo_q      <= '0;
      end else begin
         state_q    <= state_d;
         byte_idx_q <= byte_idx_d;
         asm_q      <= asm_d;
         word_cnt_q <= word_cnt_d;
         word_idx_q <= word_idx_d;
         wr_data_q  <= wr_data_d;
         tmo_q      <= tmo_d;
      end
   end

   // The word index only advances on an acknowledged write, so it doubles as the
   // written-word count.
   assign o_words_written = word_idx_q;
   assign o_wr_addr       = LOAD_BASE_ADDR + {word_idx_q[29:0], 2'b00};
   assign o_wr_data       = wr_data_q;

   assign o_rx_ready = (state_q == ST_HDR) || (state_q == ST_DATA);
   assign o_wr_en    = (state_q == ST_WRITE);
   assign o_busy     = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_WRITE);
   assign o_done     = (state_q == ST_DONE);
   assign o_error    = (state_q == ST_ERROR);
   assign o_core_rst = (state_q != ST_DONE);

endmodule

// File: tb/tb_rv32i_imem_loader.sv
module tb_rv32i_imem_loader;

   localparam logic [31:0] BASE = 32'd0;
   localparam int unsigned MAXW = 1024;
   localparam int unsigned TMO  = 64;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_start = 1'b0;
   logic        i_rx_valid = 1'b0;
   logic [7:0]  i_rx_data = 8'h00;
   logic        i_wr_valid = 1'b0;
   logic        o_rx_ready;
   logic        o_wr_en;
   logic [31:0] o_wr_addr;
   logic [31:0] o_wr_data;
   logic        o_core_rst;
   logic        o_busy;
   logic        o_done;
   logic        o_error;
   logic [31:0] o_words_written;

   always #5 i_clk = ~i_clk;

   rv32i_imem_loader #(
      .LOAD_BASE_ADDR (BASE),
      .MAX_WORDS      (MAXW),
      .WR_TIMEOUT     (TMO)
   ) dut (
      .i_clk           (i_clk),
      .i_rst           (i_rst),
      .i_start         (i_start),
      .i_rx_valid      (i_rx_valid),
      .i_rx_data       (i_rx_data),
      .o_rx_ready      (o_rx_ready),
      .o_wr_en         (o_wr_en),
      .o_wr_addr       (o_wr_addr),
      .o_wr_data       (o_wr_data),
      .i_wr_valid      (i_wr_valid),
      .o_core_rst      (o_core_rst),
      .o_busy          (o_busy),
      .o_done          (o_done),
      .o_error         (o_error),
      .o_words_written (o_words_written)
   );

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Reference model: the writes the loader still owes, in order, plus the number of
   // writes the memory has acknowledged in the current load.
   logic [31:0] exp_addr_q[$];
   logic [31:0] exp_data_q[$];
   logic [31:0] log_addr[$];
   logic [31:0] log_data[$];
   int          m_written = 0;
   int          wr_en_cycles = 0;
   bit          chk_on = 1'b0;

   bit          gaps_en = 1'b0;
   bit          noise_en = 1'b0;
   bit          ack_en = 1'b1;
   int          ack_delay = 1;

   logic [7:0]  tx_q[$];

   // Per-cycle compare, then advance the model by what the coming edge will do.
   always @(negedge i_clk) begin
      if (chk_on) begin
         check("status_onehot", 32'($onehot0({o_busy, o_done, o_error})), 32'd1);
         check("core_rst", 32'(o_core_rst), 32'(!o_done));
         check("rx_ready_in_write", 32'(o_rx_ready & o_wr_en), 32'd0);
         check("words_written", o_words_written, 32'(m_written));
         if (o_wr_en) begin
            wr_en_cycles++;
            if (exp_addr_q.size() == 0) begin
               check("unexpected_wr_en", 32'(o_wr_en), 32'd0);
            end else begin
               check("wr_addr", o_wr_addr, exp_addr_q[0]);
               check("wr_data", o_wr_data, exp_data_q[0]);
            end
         end
      end
      if (i_rst) begin
         m_written = 0;
         exp_addr_q.delete();
         exp_data_q.delete();
      end else if (o_wr_en && i_wr_valid && exp_addr_q.size() > 0) begin
         log_addr.push_back(o_wr_addr);
         log_data.push_back(o_wr_data);
         void'(exp_addr_q.pop_front());
         void'(exp_data_q.pop_front());
         m_written++;
      end else if (i_start && !o_busy) begin
         m_written = 0;
      end
   end

   // Instruction-memory model: acks ack_delay cycles into a request; optional
   // spurious acknowledges while no request is pending.
   initial begin
      int wcnt;
      wcnt = 0;
      forever begin
         @(posedge i_clk);
         #1;
         i_wr_valid = 1'b0;
         if (o_wr_en === 1'b1) begin
            wcnt++;
            if (ack_en && wcnt >= ack_delay) begin
               i_wr_valid = 1'b1;
               wcnt = 0;
            end
         end else begin
            wcnt = 0;
            if (noise_en) i_wr_valid = ($urandom_range(0, 3) == 0);
         end
      end
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
   endtask

   task automatic pulse_start();
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
   endtask

   task automatic push_word(input logic [31:0] w);
      for (int k = 0; k < 4; k++) tx_q.push_back(w[8*k +: 8]);
   endtask

   // Header N followed by N random words; expected writes recorded when N is legal.
   task automatic queue_load(input int n);
      logic [31:0] w;
      push_word(32'(n));
      for (int i = 0; i < n; i++) begin
         w = $urandom();
         push_word(w);
         exp_addr_q.push_back(BASE + 32'(4 * i));
         exp_data_q.push_back(w);
      end
   endtask

   task automatic send_bytes(input int budget);
      bit acc;
      int n;
      n = 0;
      while (tx_q.size() > 0) begin
         if (gaps_en && $urandom_range(0, 2) == 0) begin
            i_rx_valid = 1'b0;
            i_rx_data  = 8'($urandom());
         end else begin
            i_rx_valid = 1'b1;
            i_rx_data  = tx_q[0];
         end
         @(negedge i_clk);
         acc = i_rx_valid && o_rx_ready;
         tick();
         if (acc) void'(tx_q.pop_front());
         n++;
         if (n > budget) begin
            check("tx_timeout", 32'(tx_q.size()), 32'd0);
            tx_q.delete();
         end
      end
      i_rx_valid = 1'b0;
   endtask

   task automatic wait_end(input int budget);
      int n;
      n = 0;
      while (!(o_done || o_error) && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) check("end_timeout", 32'(o_done | o_error), 32'd1);
   endtask

   task automatic check_reset_vals();
      check("rst_wr_en", 32'(o_wr_en), 32'd0);
      check("rst_wr_addr", o_wr_addr, BASE);
      check("rst_wr_data", o_wr_data, 32'd0);
      check("rst_words", o_words_written, 32'd0);
      check("rst_core_rst", 32'(o_core_rst), 32'd1);
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_done", 32'(o_done), 32'd0);
      check("rst_error", 32'(o_error), 32'd0);
      check("rst_rx_ready", 32'(o_rx_ready), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks so far %0d/%0d", n_pass, n_total);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] t1 [12];
      logic [7:0] t3 [4];
      int n;

      tick();
      do_reset();
      chk_on = 1'b1;
      check_reset_vals();

      // Two-word program, memory acks one cycle into each request.
      t1 = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
             8'h93, 8'h00, 8'h10, 8'h00};
      foreach (t1[i]) tx_q.push_back(t1[i]);
      exp_addr_q.push_back(32'h0);
      exp_data_q.push_back(32'h0000_0013);
      exp_addr_q.push_back(32'h4);
      exp_data_q.push_back(32'h0010_0093);
      log_addr.delete();
      log_data.delete();
      pulse_start();
      check("start_core_rst", 32'(o_core_rst), 32'd1);
      send_bytes(200);
      wait_end(200);
      check("t1_done", 32'(o_done), 32'd1);
      check("t1_words", o_words_written, 32'd2);
      check("t1_core_rst", 32'(o_core_rst), 32'd0);
      check("t1_nwrites", 32'(log_addr.size()), 32'd2);
      check("t1_addr0", log_addr[0], 32'h0);
      check("t1_data0", log_data[0], 32'h0000_0013);
      check("t1_addr1", log_addr[1], 32'h4);
      check("t1_data1", log_data[1], 32'h0010_0093);

      // Empty program: straight to DONE with no write request.
      wr_en_cycles = 0;
      push_word(32'd0);
      pulse_start();
      send_bytes(100);
      wait_end(50);
      check("t2_done", 32'(o_done), 32'd1);
      check("t2_words", o_words_written, 32'd0);
      check("t2_wr_en_cycles", 32'(wr_en_cycles), 32'd0);

      // Oversized header: 1025 words.
      t3 = '{8'h01, 8'h04, 8'h00, 8'h00};
      foreach (t3[i]) tx_q.push_back(t3[i]);
      pulse_start();
      send_bytes(100);
      wait_end(50);
      check("t3_error", 32'(o_error), 32'd1);
      check("t3_core_rst", 32'(o_core_rst), 32'd1);
      check("t3_rx_ready", 32'(o_rx_ready), 32'd0);
      for (int i = 0; i < 5; i++) tick();
      check("t3_error_sticky", 32'(o_error), 32'd1);
      pulse_start();
      check("t3_restart_error", 32'(o_error), 32'd0);
      check("t3_restart_busy", 32'(o_busy), 32'd1);
      check("t3_restart_ready", 32'(o_rx_ready), 32'd1);
      push_word(32'd0);
      send_bytes(100);
      wait_end(50);
      check("t3_recover_done", 32'(o_done), 32'd1);

      // Memory never acknowledges: request visible for exactly TMO cycles.
      ack_en = 1'b0;
      wr_en_cycles = 0;
      queue_load(1);
      pulse_start();
      send_bytes(100);
      wait_end(400);
      check("t4_error", 32'(o_error), 32'd1);
      check("t4_wr_en_cycles", 32'(wr_en_cycles), 32'(TMO));
      check("t4_words", o_words_written, 32'd0);
      check("t4_wr_en_off", 32'(o_wr_en), 32'd0);
      exp_addr_q.delete();
      exp_data_q.delete();
      ack_en = 1'b1;

      // Random loads with byte gaps, slow acks and spurious acks outside WRITE.
      gaps_en  = 1'b1;
      noise_en = 1'b1;
      for (int it = 0; it < 6; it++) begin
         ack_delay = (it == 0) ? 5 : int'($urandom_range(1, 6));
         n = int'($urandom_range(1, 6));
         queue_load(n);
         pulse_start();
         send_bytes(2000);
         wait_end(2000);
         check("t5_done", 32'(o_done), 32'd1);
         check("t5_words", o_words_written, 32'(n));
         check("t5_all_written", 32'(exp_addr_q.size()), 32'd0);
      end
      gaps_en   = 1'b0;
      noise_en  = 1'b0;
      ack_delay = 1;

      // Reset in the middle of a data word, then a clean single-word load.
      push_word(32'd1);
      tx_q.push_back(8'hAA);
      tx_q.push_back(8'h55);
      pulse_start();
      send_bytes(100);
      check("t6_in_data", 32'(o_busy), 32'd1);
      do_reset();
      check_reset_vals();
      for (int i = 0; i < 3; i++) tick();
      check("t6_idle_words", o_words_written, 32'd0);
      log_addr.delete();
      log_data.delete();
      queue_load(1);
      pulse_start();
      send_bytes(100);
      wait_end(100);
      check("t6_done", 32'(o_done), 32'd1);
      check("t6_words", o_words_written, 32'd1);
      check("t6_addr", log_addr[0], 32'h0);

      tick();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
